// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline: hit/match inputs in,
// latch commands, forwarding selects and performance counters out.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ihit, dhit, dmem_req;
  logic [REG_W-1:0] rs, rt, ex_rs, ex_rt;
  logic [REG_W-1:0] ex_wsel, mem_wsel, wb_wsel;
  logic             ex_wen, mem_wen, wb_wen;
  logic             ex_memread, br_taken, jump_id, wb_halt, cnt_clr;
  logic             pc_wen;
  logic [1:0]       fd_state, de_state, em_state, mw_state;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport slave (
    input  ihit, dhit, dmem_req, rs, rt, ex_rs, ex_rt,
           ex_wsel, mem_wsel, wb_wsel, ex_wen, mem_wen, wb_wen,
           ex_memread, br_taken, jump_id, wb_halt, cnt_clr,
    output pc_wen, fd_state, de_state, em_state, mw_state,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, dmem_req, rs, rt, ex_rs, ex_rt,
           ex_wsel, mem_wsel, wb_wsel, ex_wen, mem_wen, wb_wen,
           ex_memread, br_taken, jump_id, wb_halt, cnt_clr,
    input  pc_wen, fd_state, de_state, em_state, mw_state,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: PC enable, per-latch
// RUN/STALL/FLUSH commands, operand forwarding and stall/flush counters.
//
//   state    | meaning
//   ST_RUN   | normal issue, hazard rules active
//   ST_DWAIT | data-cache miss in progress, whole pipe frozen
//   ST_HALT  | halt retired in WB, pipe held until reset
module hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic          CLK,
  input logic          nRST,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DWAIT = 2'd1, ST_HALT = 2'd2} state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STALL = 2'b01;
  localparam logic [1:0] CMD_FLUSH = 2'b10;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEM   = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             freeze, id_vs_ex, id_vs_mem, id_hazard, redirect, pc_wen;
  logic [1:0]       fd_cmd, de_cmd, em_cmd, mw_cmd, fwd_a, fwd_b;

  function automatic logic raw_match(input logic wen, input logic [REG_W-1:0] wsel,
                                     input logic [REG_W-1:0] src);
    return wen && (wsel != '0) && (wsel == src);
  endfunction

  // WB writes the regfile in the first half-cycle, so ID only checks EX and MEM.
  always_comb begin
    id_vs_ex  = raw_match(hz.ex_wen, hz.ex_wsel, hz.rs) ||
                raw_match(hz.ex_wen, hz.ex_wsel, hz.rt);
    id_vs_mem = raw_match(hz.mem_wen, hz.mem_wsel, hz.rs) ||
                raw_match(hz.mem_wen, hz.mem_wsel, hz.rt);
    id_hazard = FWD_EN ? (hz.ex_memread && id_vs_ex) : (id_vs_ex || id_vs_mem);
    freeze    = hz.dmem_req && !hz.dhit && (state_q != ST_HALT);
  end

  always_comb begin
    pc_wen   = 1'b0;
    fd_cmd   = CMD_RUN;
    de_cmd   = CMD_RUN;
    em_cmd   = CMD_RUN;
    mw_cmd   = CMD_RUN;
    redirect = 1'b0;
    fwd_a    = FWD_REG;
    fwd_b    = FWD_REG;
    // MEM is the youngest producer, so it beats WB.
    if (FWD_EN) begin
      if (raw_match(hz.mem_wen, hz.mem_wsel, hz.ex_rs))     fwd_a = FWD_MEM;
      else if (raw_match(hz.wb_wen, hz.wb_wsel, hz.ex_rs))  fwd_a = FWD_WB;
      if (raw_match(hz.mem_wen, hz.mem_wsel, hz.ex_rt))     fwd_b = FWD_MEM;
      else if (raw_match(hz.wb_wen, hz.wb_wsel, hz.ex_rt))  fwd_b = FWD_WB;
    end
    if (!nRST) begin
      fd_cmd = CMD_FLUSH;
      de_cmd = CMD_FLUSH;
      em_cmd = CMD_FLUSH;
      mw_cmd = CMD_FLUSH;
      fwd_a  = FWD_REG;
      fwd_b  = FWD_REG;
    end else if (state_q == ST_HALT || freeze) begin
      fd_cmd = CMD_STALL;
      de_cmd = CMD_STALL;
      em_cmd = CMD_STALL;
      mw_cmd = CMD_STALL;
    end else if (hz.br_taken) begin
      pc_wen   = 1'b1;
      fd_cmd   = CMD_FLUSH;
      de_cmd   = CMD_FLUSH;
      redirect = 1'b1;
    end else if (id_hazard) begin
      fd_cmd = CMD_STALL;
      de_cmd = CMD_FLUSH;
    end else if (hz.jump_id) begin
      pc_wen   = 1'b1;
      fd_cmd   = CMD_FLUSH;
      redirect = 1'b1;
    end else if (!hz.ihit) begin
      fd_cmd = CMD_FLUSH;
    end else begin
      pc_wen = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    // An active freeze defers a pending halt until the miss resolves.
    if (state_q != ST_HALT) begin
      if (freeze)            state_d = ST_DWAIT;
      else if (hz.wb_halt)   state_d = ST_HALT;
      else                   state_d = ST_RUN;
    end
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_wen && state_q != ST_HALT && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_wen    = pc_wen;
  assign hz.fd_state  = fd_cmd;
  assign hz.de_state  = de_cmd;
  assign hz.em_state  = em_cmd;
  assign hz.mw_state  = mw_cmd;
  assign hz.fwd_a     = fwd_a;
  assign hz.fwd_b     = fwd_b;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (forwarding, no forwarding, 2-bit
// counters) share one stimulus and are checked against a rule-list model.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dmem_req, ex_wen, mem_wen, wb_wen;
  logic       ex_memread, br_taken, jump_id, wb_halt, cnt_clr;
  logic [4:0] rs, rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;

  logic [2:0]       pcw;
  logic [2:0][1:0]  fd, de, em, mw, fa, fb;
  logic [2:0][15:0] sc, fc;

  int vectors = 0;
  int miscompares = 0;

  bit halted[3];
  int scnt[3];
  int fcnt[3];
  int cmax[3] = '{65535, 65535, 3};

  typedef struct packed {
    logic       pcw;
    logic [1:0] fd, de, em, mw, fa, fb;
    logic       sinc, finc;
  } exp_t;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit FE = (g != 1);
    localparam int CW = (g == 2) ? 2 : 16;
    hazard_ctrl_if #(.REG_W(5), .CNT_W(CW)) bus ();
    assign bus.ihit = ihit;             assign bus.dhit = dhit;
    assign bus.dmem_req = dmem_req;     assign bus.rs = rs;
    assign bus.rt = rt;                 assign bus.ex_rs = ex_rs;
    assign bus.ex_rt = ex_rt;           assign bus.ex_wsel = ex_wsel;
    assign bus.mem_wsel = mem_wsel;     assign bus.wb_wsel = wb_wsel;
    assign bus.ex_wen = ex_wen;         assign bus.mem_wen = mem_wen;
    assign bus.wb_wen = wb_wen;         assign bus.ex_memread = ex_memread;
    assign bus.br_taken = br_taken;     assign bus.jump_id = jump_id;
    assign bus.wb_halt = wb_halt;       assign bus.cnt_clr = cnt_clr;
    assign pcw[g] = bus.pc_wen;
    assign fd[g] = bus.fd_state;        assign de[g] = bus.de_state;
    assign em[g] = bus.em_state;        assign mw[g] = bus.mw_state;
    assign fa[g] = bus.fwd_a;           assign fb[g] = bus.fwd_b;
    assign sc[g] = 16'(bus.stall_cnt);  assign fc[g] = 16'(bus.flush_cnt);
    hazard_ctrl #(.FWD_EN(FE), .REG_W(5), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST), .hz(bus)
    );
  end

  function automatic bit writes(bit wen, logic [4:0] dst, logic [4:0] src);
    return wen && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] fwd_of(bit fe, logic [4:0] src);
    if (!fe) return 2'd0;
    if (writes(mem_wen, mem_wsel, src)) return 2'd1;
    if (writes(wb_wen, wb_wsel, src)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model(bit fe, bit is_halted);
    exp_t e;
    bit ex_hit, mem_hit, hzd;
    e = '0;
    if (!nRST) begin
      {e.fd, e.de, e.em, e.mw} = 8'b10_10_10_10;
      return e;
    end
    e.fa    = fwd_of(fe, ex_rs);
    e.fb    = fwd_of(fe, ex_rt);
    ex_hit  = writes(ex_wen, ex_wsel, rs) || writes(ex_wen, ex_wsel, rt);
    mem_hit = writes(mem_wen, mem_wsel, rs) || writes(mem_wen, mem_wsel, rt);
    hzd     = fe ? (ex_memread && ex_hit) : (ex_hit || mem_hit);
    if (is_halted || (dmem_req && !dhit)) {e.fd, e.de, e.em, e.mw} = 8'b01_01_01_01;
    else if (br_taken) begin e.pcw = 1; e.fd = 2; e.de = 2; e.finc = 1; end
    else if (hzd)      begin e.fd = 1; e.de = 2; end
    else if (jump_id)  begin e.pcw = 1; e.fd = 2; e.finc = 1; end
    else if (!ihit)    e.fd = 2;
    else               e.pcw = 1;
    e.sinc = !is_halted && !e.pcw;
    return e;
  endfunction

  // Advances one clock and the model's state/counters along with it.
  task automatic tick();
    exp_t e;
    bit nh[3];
    int ns[3], nf[3];
    for (int i = 0; i < 3; i++) begin
      e = model(i != 1, halted[i]);
      if (!nRST) begin
        nh[i] = 0; ns[i] = 0; nf[i] = 0;
      end else begin
        nh[i] = halted[i] || (wb_halt && !(dmem_req && !dhit));
        ns[i] = cnt_clr ? 0 : (scnt[i] + int'(e.sinc) > cmax[i] ? cmax[i] : scnt[i] + int'(e.sinc));
        nf[i] = cnt_clr ? 0 : (fcnt[i] + int'(e.finc) > cmax[i] ? cmax[i] : fcnt[i] + int'(e.finc));
      end
    end
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      halted[i] = nh[i]; scnt[i] = ns[i]; fcnt[i] = nf[i];
    end
    #1;
  endtask

  task automatic idle();
    nRST = 1; ihit = 1; dhit = 0; dmem_req = 0;
    ex_wen = 0; mem_wen = 0; wb_wen = 0; ex_memread = 0;
    br_taken = 0; jump_id = 0; wb_halt = 0; cnt_clr = 0;
    rs = 0; rt = 0; ex_rs = 0; ex_rt = 0; ex_wsel = 0; mem_wsel = 0; wb_wsel = 0;
  endtask

  task automatic test_reset();
    idle(); nRST = 0; ihit = 0; br_taken = 1; mem_wen = 1; mem_wsel = 3; ex_rs = 3;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({pcw[i], fd[i], de[i], em[i], mw[i], fa[i]} !== 11'b0_10_10_10_10_00) begin
        miscompares++;
        $display("FAIL reset_cmd[%0d]: got %b want %b", i,
                 {pcw[i], fd[i], de[i], em[i], mw[i], fa[i]}, 11'b0_10_10_10_10_00);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sc[i] !== 16'd0 || fc[i] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", i, sc[i], fc[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [15:0] s0;
    idle(); ex_memread = 1; ex_wen = 1; ex_wsel = 2; rs = 2;
    #1; s0 = sc[0];
    vectors++;
    if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b0_01_10_00_00) begin
      miscompares++;
      $display("FAIL load_use_cmd: got %b want %b", {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b0_01_10_00_00);
    end
    tick();
    idle(); wb_wen = 1; wb_wsel = 2; ex_rs = 2;
    #1;
    vectors++;
    if ({pcw[0], fa[0], fa[1]} !== 5'b1_10_00) begin
      miscompares++;
      $display("FAIL load_use_fwd: got %b want %b", {pcw[0], fa[0], fa[1]}, 5'b1_10_00);
    end
    vectors++;
    if (sc[0] - s0 !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_stalls: got %0d want 1", sc[0] - s0);
    end
    tick();
  endtask

  task automatic test_double_producer();
    idle(); mem_wen = 1; wb_wen = 1; mem_wsel = 7; wb_wsel = 7; ex_rt = 7;
    #1;
    vectors++;
    if ({fb[0], fb[1]} !== 4'b01_00) begin
      miscompares++;
      $display("FAIL double_mem: got %b want %b", {fb[0], fb[1]}, 4'b01_00);
    end
    mem_wen = 0; #1;
    vectors++;
    if (fb[0] !== 2'b10) begin
      miscompares++;
      $display("FAIL double_wb: got %b want 10", fb[0]);
    end
    mem_wen = 1; ex_rt = 0; mem_wsel = 0; wb_wsel = 0; #1;
    vectors++;
    if (fb[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL double_r0: got %b want 00", fb[0]);
    end
    tick();
  endtask

  task automatic test_data_miss();
    logic [15:0] s0, f0;
    idle(); dmem_req = 1; dhit = 0; br_taken = 1;
    #1; s0 = sc[0]; f0 = fc[0];
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b0_01_01_01_01) begin
        miscompares++;
        $display("FAIL dmiss_freeze c%0d: got %b want %b", c, {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b0_01_01_01_01);
      end
      tick();
    end
    dhit = 1; #1;
    vectors++;
    if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b1_10_10_00_00) begin
      miscompares++;
      $display("FAIL dmiss_release: got %b want %b", {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b1_10_10_00_00);
    end
    tick();
    idle(); #1;
    vectors++;
    if (sc[0] - s0 !== 16'd3 || fc[0] - f0 !== 16'd1) begin
      miscompares++;
      $display("FAIL dmiss_cnt: got %0d/%0d want 3/1", sc[0] - s0, fc[0] - f0);
    end
  endtask

  task automatic test_branch_imiss();
    logic [15:0] s0, f0;
    idle(); br_taken = 1; ihit = 0; ex_memread = 1; ex_wen = 1; ex_wsel = 2; rs = 2;
    #1; s0 = sc[0]; f0 = fc[0];
    vectors++;
    if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b1_10_10_00_00) begin
      miscompares++;
      $display("FAIL branch_cmd: got %b want %b", {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b1_10_10_00_00);
    end
    tick();
    idle(); #1;
    vectors++;
    if (fc[0] - f0 !== 16'd1 || sc[0] - s0 !== 16'd0) begin
      miscompares++;
      $display("FAIL branch_cnt: got flush %0d stall %0d want 1/0", fc[0] - f0, sc[0] - s0);
    end
  endtask

  task automatic test_no_forward();
    logic [15:0] s1;
    idle(); ex_wen = 1; ex_wsel = 4; rs = 4;
    #1; s1 = sc[1];
    vectors++;
    if ({pcw[1], fd[1], de[1], pcw[0]} !== 6'b0_01_10_1) begin
      miscompares++;
      $display("FAIL nofwd_ex: got %b want %b", {pcw[1], fd[1], de[1], pcw[0]}, 6'b0_01_10_1);
    end
    tick();
    ex_wen = 0; mem_wen = 1; mem_wsel = 4; #1;
    vectors++;
    if ({pcw[1], fd[1], de[1]} !== 5'b0_01_10) begin
      miscompares++;
      $display("FAIL nofwd_mem: got %b want %b", {pcw[1], fd[1], de[1]}, 5'b0_01_10);
    end
    tick();
    mem_wen = 0; wb_wen = 1; wb_wsel = 4; #1;
    vectors++;
    if ({pcw[1], fd[1], de[1], em[1], mw[1]} !== 9'b1_00_00_00_00 || sc[1] - s1 !== 16'd2) begin
      miscompares++;
      $display("FAIL nofwd_release: got %b stalls %0d want %b stalls 2",
               {pcw[1], fd[1], de[1], em[1], mw[1]}, sc[1] - s1, 9'b1_00_00_00_00);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [15:0] s0;
    idle(); dmem_req = 1; wb_halt = 1; #1;
    vectors++;
    if ({pcw[0], fd[0], mw[0]} !== 5'b0_01_01) begin
      miscompares++;
      $display("FAIL halt_freeze: got %b want %b", {pcw[0], fd[0], mw[0]}, 5'b0_01_01);
    end
    tick();
    dhit = 1; #1;
    vectors++;
    if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b1_00_00_00_00) begin
      miscompares++;
      $display("FAIL halt_deferred: got %b want %b", {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b1_00_00_00_00);
    end
    tick();
    idle(); br_taken = 1; #1; s0 = sc[0];
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b0_01_01_01_01) begin
        miscompares++;
        $display("FAIL halt_hold c%0d: got %b want %b", c, {pcw[0], fd[0], de[0], em[0], mw[0]}, 9'b0_01_01_01_01);
      end
      tick();
    end
    vectors++;
    if (sc[0] !== s0) begin
      miscompares++;
      $display("FAIL halt_nostall: got %0d want %0d", sc[0], s0);
    end
    idle(); nRST = 0; tick();
    nRST = 1; #1;
    vectors++;
    if ({pcw[0], fd[0], de[0], em[0], mw[0]} !== 9'b1_00_00_00_00 || sc[0] !== 16'd0 || fc[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL halt_reset: got %b cnt %0d/%0d want %b cnt 0/0",
               {pcw[0], fd[0], de[0], em[0], mw[0]}, sc[0], fc[0], 9'b1_00_00_00_00);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle(); ihit = 0;
    for (int c = 0; c < 5; c++) tick();
    vectors++;
    if (sc[2] !== 16'd3 || sc[0] !== 16'd5) begin
      miscompares++;
      $display("FAIL sat_stall: got %0d/%0d want 3/5", sc[2], sc[0]);
    end
    ihit = 1; jump_id = 1;
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if (fc[2] !== 16'd3 || fc[0] !== 16'd4) begin
      miscompares++;
      $display("FAIL sat_flush: got %0d/%0d want 3/4", fc[2], fc[0]);
    end
    ihit = 0; cnt_clr = 1; tick();
    vectors++;
    if ({sc[2], fc[2], sc[0], fc[0]} !== 64'd0) begin
      miscompares++;
      $display("FAIL cnt_clr: got %0d %0d %0d %0d want 0", sc[2], fc[2], sc[0], fc[0]);
    end
    idle();
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      nRST = ($urandom % 40) != 0;     ihit = ($urandom % 8) != 0;
      dmem_req = ($urandom % 3) == 0;  dhit = $urandom % 2;
      br_taken = ($urandom % 8) == 0;  jump_id = ($urandom % 8) == 0;
      wb_halt = ($urandom % 50) == 0;  cnt_clr = ($urandom % 30) == 0;
      ex_wen = $urandom % 2; mem_wen = $urandom % 2; wb_wen = $urandom % 2;
      ex_memread = $urandom % 2;
      rs = 5'($urandom_range(0, 3));       rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3));    ex_rt = 5'($urandom_range(0, 3));
      ex_wsel = 5'($urandom_range(0, 3));  mem_wsel = 5'($urandom_range(0, 3));
      wb_wsel = 5'($urandom_range(0, 3));
      #1;
      for (int i = 0; i < 3; i++) begin
        e = model(i != 1, halted[i]);
        vectors++;
        if ({pcw[i], fd[i], de[i], em[i], mw[i], fa[i], fb[i]} !== {e.pcw, e.fd, e.de, e.em, e.mw, e.fa, e.fb}) begin
          miscompares++;
          $display("FAIL rand_cmd[%0d] n%0d: got %b want %b", i, n,
                   {pcw[i], fd[i], de[i], em[i], mw[i], fa[i], fb[i]}, {e.pcw, e.fd, e.de, e.em, e.mw, e.fa, e.fb});
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (sc[i] !== 16'(scnt[i]) || fc[i] !== 16'(fcnt[i])) begin
          miscompares++;
          $display("FAIL rand_cnt[%0d] n%0d: got %0d/%0d want %0d/%0d", i, n, sc[i], fc[i], scnt[i], fcnt[i]);
        end
      end
    end
  endtask

  initial begin
    idle(); nRST = 0;
    test_reset();
    test_load_use();
    test_double_producer();
    test_data_miss();
    test_branch_imiss();
    test_no_forward();
    test_halt();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
